baseline_subtractor: RTL and testbench
======================================

// Module: baseline_subtractor
// PURPOSE
//  Downstream consumer of the boxcar baseline estimate: subtracts the 16-bit
//  baseline from the raw ADC stream to give a baseline-restored signed sample.
//  Emits a one-cycle trigger on rising threshold crossings, with holdoff.
//  Sits between the boxcar filter output and the self-trigger/readout logic.
// PARAMETERS
//  DELAY        4       x alignment delay in samples, legal 1..15
//  SETTLE_LOG2  4       baseline_valid must hold 2**SETTLE_LOG2 consecutive cycles before RUN
//  THRESH       16'sd200  signed trigger threshold on y
//  HOLDOFF      8       cycles after a trigger during which trig is suppressed, legal 1..255
// PORTS
//  clk             in   1   sample clock, one sample per cycle
//  reset           in   1   asynchronous, active-low reset
//  en              in   1   channel enable; 0 forces IDLE
//  x               in   16  signed raw sample
//  baseline        in   16  signed baseline from boxcar stage
//  baseline_valid  in   1   baseline is latched and usable
//  y               out  16  signed saturated x_delayed - baseline; 0 when not RUN
//  y_valid         out  1   y is meaningful (state==RUN)
//  trig            out  1   single-cycle threshold-crossing pulse
//  state_o         out  2   FSM state: IDLE=0, WAIT=1, RUN=2
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, delay line, counters, y, y_valid, trig, prev_above all 0.
//  - Delay line: DELAY-deep shift of x, advances every cycle with en==1; cleared when en==0.
//  - Arithmetic: diff = {xd[15],xd} - {baseline[15],baseline} (17 bit), saturated to
//    [-32768, 32767]; y registered, so y(t) uses x(t-DELAY-1) and baseline(t-1).
//  - FSM, evaluated each clk:
//    IDLE: outputs 0; en==1 -> WAIT.
//    WAIT: settle_cnt increments while baseline_valid==1, clears to 0 on baseline_valid==0;
//      reaching 2**SETTLE_LOG2-1 with baseline_valid==1 -> RUN. y=0, y_valid=0.
//    RUN: y=sat diff, y_valid=1. baseline_valid==0 -> WAIT (settle_cnt=0, y=0 next cycle).
//    Any state: en==0 -> IDLE next cycle (highest priority).
//    Encoding 3 is illegal -> IDLE.
//  - Trigger, RUN only: above = (sat diff > THRESH). trig=1 for one cycle when
//    above && !prev_above && hold_cnt==0; then hold_cnt loads HOLDOFF, decrements
//    to 0 once per cycle. prev_above updates every RUN cycle; it and hold_cnt clear
//    on leaving RUN.
//  - Simultaneous: crossing in the same cycle baseline_valid drops or en falls -> no trig.
//    Crossing while hold_cnt!=0 -> suppressed; not deferred.
//  - Saturation: x=32767, baseline=-32768 -> y=32767; x=-32768, baseline=32767 -> y=-32768.
//  - Reset mid-RUN: all outputs 0 immediately (async), restarts from IDLE.
// STRUCTURE
//  - Shared package: state encodings (IDLE/WAIT/RUN), SAT_MAX=16'sh7FFF,
//    SAT_MIN=16'sh8000.
//  - Sub-module: sample_delay_line (params WIDTH, DEPTH; clk, reset, en, clr, din, dout).
//  - Top level holds FSM, settle counter, subtract/saturate, trigger/holdoff.
// TESTING
//  1 reset low mid-RUN -> y, y_valid, trig, state_o go 0 without clk edge; recover via IDLE->WAIT->RUN.
//  2 en=1, baseline_valid=1, baseline=100, x=100 constant -> state_o RUN after 16 cycles, y=0, y_valid=1.
//  3 RUN, baseline=100, x steps 100->400 -> y=300 exactly DELAY+1 cycles later; trig one cycle.
//  4 RUN, x pulses 400 every 4 cycles, HOLDOFF=8 -> trig on the 1st pulse and on every 3rd
//    pulse after (pulses 1,4,7); intermediate crossings suppressed.
//  5 x=32767, baseline=-32768 -> y=32767; x=-32768, baseline=32767 -> y=-32768.
//  6 baseline_valid drops 1 cycle in RUN -> WAIT, y_valid 0, RUN re-entered 16 cycles after it
//    returns; en=0 -> IDLE, delay line reads 0 on re-enable.

Source files
------------

// File: rtl/baseline_subtractor_pkg.sv
// Shared encodings and saturation helper for the baseline restoration stage.
package baseline_subtractor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  // A 17-bit difference overflows 16 bits exactly when its top two bits disagree.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? SAT_MIN : SAT_MAX;
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/baseline_subtractor_delay.sv
// Fixed-depth sample shift register that aligns x with the registered baseline.
module sample_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      logic [WIDTH-1:0] d_next;

      if (gi == 0) begin : g_head
        assign d_next = din;
      end else begin : g_tail
        assign d_next = g_stage[gi-1].q_reg;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q_reg <= '0;
        end else if (clr) begin
          q_reg <= '0;
        end else if (en) begin
          q_reg <= d_next;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/baseline_subtractor.sv
// Baseline restoration: delayed x minus baseline, saturated to 16 bits, with a
// held-off trigger on rising threshold crossings once the baseline has settled.
module baseline_subtractor
  import baseline_subtractor_pkg::*;
#(
  parameter int                 DELAY       = 4,
  parameter int                 SETTLE_LOG2 = 4,
  parameter logic signed [15:0] THRESH      = 16'sd200,
  parameter int                 HOLDOFF     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic signed [15:0] x,
  input  logic signed [15:0] baseline,
  input  logic               baseline_valid,
  output logic signed [15:0] y,
  output logic               y_valid,
  output logic               trig,
  output logic [1:0]         state_o
);

  localparam logic [SETTLE_LOG2-1:0] SETTLE_LAST = '1;
  localparam logic [7:0]             HOLD_LOAD   = 8'(HOLDOFF);

  state_t                 state_reg, state_next;
  logic [SETTLE_LOG2-1:0] settle_reg, settle_next;
  logic [7:0]             hold_reg, hold_next;
  logic                   prev_above_reg, prev_above_next;
  logic signed [15:0]     y_reg, y_next;
  logic                   y_valid_reg;
  logic                   trig_reg, trig_next;
  logic signed [15:0]     xd;
  logic signed [15:0]     sat_diff;
  logic signed [16:0]     diff;
  logic                   run_next;
  logic                   above;

  sample_delay_line #(
    .WIDTH(16),
    .DEPTH(DELAY)
  ) u_delay (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (!en),
    .din  (x),
    .dout (xd)
  );

  always_comb begin
    state_next  = ST_IDLE;
    settle_next = '0;
    if (en) begin
      case (state_reg)
        ST_IDLE: state_next = ST_WAIT;
        ST_WAIT: begin
          state_next = ST_WAIT;
          if (baseline_valid) begin
            if (settle_reg == SETTLE_LAST) begin
              state_next = ST_RUN;
            end else begin
              settle_next = settle_reg + SETTLE_LOG2'(1);
            end
          end
        end
        ST_RUN:  state_next = baseline_valid ? ST_RUN : ST_WAIT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign diff     = {xd[15], xd} - {baseline[15], baseline};
  assign sat_diff = sat16(diff);
  assign above    = (sat_diff > THRESH);
  // Outputs are qualified by the state being entered, so a crossing that
  // coincides with leaving RUN never produces a trigger.
  assign run_next = (state_next == ST_RUN);

  always_comb begin
    y_next          = '0;
    trig_next       = 1'b0;
    prev_above_next = 1'b0;
    hold_next       = '0;
    if (run_next) begin
      y_next          = sat_diff;
      trig_next       = above && !prev_above_reg && (hold_reg == '0);
      prev_above_next = above;
      if (trig_next) begin
        hold_next = HOLD_LOAD;
      end else if (hold_reg != '0) begin
        hold_next = hold_reg - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      settle_reg     <= '0;
      hold_reg       <= '0;
      prev_above_reg <= 1'b0;
      y_reg          <= '0;
      y_valid_reg    <= 1'b0;
      trig_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      settle_reg     <= settle_next;
      hold_reg       <= hold_next;
      prev_above_reg <= prev_above_next;
      y_reg          <= y_next;
      y_valid_reg    <= run_next;
      trig_reg       <= trig_next;
    end
  end

  assign y       = y_reg;
  assign y_valid = y_valid_reg;
  assign trig    = trig_reg;
  assign state_o = state_reg;

endmodule

// File: tb/tb_baseline_subtractor.sv
// Self-checking bench: cycle-by-cycle comparison against a behavioural model,
// plus directed literal checks for settling, step latency, holdoff and saturation.
module tb_baseline_subtractor;

  localparam int DELAY         = 4;
  localparam int SETTLE_CYCLES = 16;
  localparam int THRESH        = 200;
  localparam int HOLDOFF       = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic signed [15:0] x;
  logic signed [15:0] baseline;
  logic               baseline_valid;
  logic signed [15:0] y;
  logic               y_valid;
  logic               trig;
  logic [1:0]         state_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  baseline_subtractor #(
    .DELAY(DELAY),
    .SETTLE_LOG2(4),
    .THRESH(16'sd200),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .en            (en),
    .x             (x),
    .baseline      (baseline),
    .baseline_valid(baseline_valid),
    .y             (y),
    .y_valid       (y_valid),
    .trig          (trig),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: state from counted runs of valid baseline, y from the
  // history of enabled samples, trigger from edge distance to the last trigger.
  int m_state     = 0;
  int m_valid_run = 0;
  int m_y         = 0;
  int m_edge      = 0;
  int m_last_trig = -1000;
  bit m_yv        = 1'b0;
  bit m_trig      = 1'b0;
  bit m_prev_abv  = 1'b0;
  int xhist[$];
  int m_xd;
  int m_d;
  bit m_abv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_valid_run = 0; m_y = 0; m_yv = 1'b0; m_trig = 1'b0;
      m_prev_abv = 1'b0; m_last_trig = -1000; m_edge = 0;
      xhist.delete();
    end else begin
      m_edge++;
      m_xd = (xhist.size() >= DELAY) ? xhist[xhist.size() - DELAY] : 0;
      if (!en) xhist.delete();
      else begin
        xhist.push_back(int'(x));
        if (xhist.size() > 32) void'(xhist.pop_front());
      end
      if (!en) m_state = 0;
      else if (m_state == 0) begin
        m_state = 1; m_valid_run = 0;
      end else if (m_state == 1) begin
        m_valid_run = baseline_valid ? m_valid_run + 1 : 0;
        if (m_valid_run == SETTLE_CYCLES) begin
          m_state = 2; m_valid_run = 0;
        end
      end else if (!baseline_valid) begin
        m_state = 1; m_valid_run = 0;
      end
      if (m_state == 2) begin
        m_d = m_xd - int'(baseline);
        if (m_d > 32767) m_d = 32767;
        if (m_d < -32768) m_d = -32768;
        m_y    = m_d;
        m_yv   = 1'b1;
        m_abv  = (m_d > THRESH);
        m_trig = m_abv && !m_prev_abv && (m_edge - m_last_trig > HOLDOFF);
        if (m_trig) m_last_trig = m_edge;
        m_prev_abv = m_abv;
      end else begin
        m_y = 0; m_yv = 1'b0; m_trig = 1'b0; m_prev_abv = 1'b0; m_last_trig = -1000;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_state", int'(state_o), m_state);
      check("cyc_y_valid", int'(y_valid), int'(m_yv));
      check("cyc_y", int'(y), m_y);
      check("cyc_trig", int'(trig), int'(m_trig));
    end
  end

  initial begin
    int k;
    int exp_t;
    int n_trig;
    rst_n = 1'b0; en = 1'b0; x = '0; baseline = '0; baseline_valid = 1'b0;
    chk_on = 1'b1;
    tick(2);
    check("rst_y", int'(y), 0);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_trig", int'(trig), 0);
    check("rst_state", int'(state_o), 0);
    rst_n = 1'b1;
    tick(1);
    check("idle_while_disabled", int'(state_o), 0);
    $display("[TB] reset and idle checked");

    en = 1'b1; baseline_valid = 1'b1; baseline = 16'sd100; x = 16'sd100;
    tick(1);
    check("wait_entry", int'(state_o), 1);
    tick(15);
    check("wait_after_15_valid", int'(state_o), 1);
    tick(1);
    check("run_after_16_valid", int'(state_o), 2);
    check("run_y_zero", int'(y), 0);
    check("run_y_valid", int'(y_valid), 1);
    $display("[TB] settle to RUN checked");

    tick(3);
    x = 16'sd400;
    tick(DELAY);
    check("step_y_before", int'(y), 0);
    check("step_trig_before", int'(trig), 0);
    tick(1);
    check("step_y", int'(y), 300);
    check("step_trig", int'(trig), 1);
    tick(1);
    check("step_y_hold", int'(y), 300);
    check("step_trig_single", int'(trig), 0);
    $display("[TB] step latency checked");

    x = 16'sd100;
    tick(12);
    n_trig = 0;
    for (int c = 0; c < 48; c++) begin
      x = (c < 40 && (c % 4) == 0) ? 16'sd400 : 16'sd100;
      tick(1);
      k = c - DELAY;
      exp_t = (k >= 0 && (k % 4) == 0 && ((k / 4) % 3) == 0) ? 1 : 0;
      check("holdoff_trig", int'(trig), exp_t);
      n_trig += int'(trig);
    end
    check("holdoff_trig_count", n_trig, 4);
    $display("[TB] holdoff pulse train checked");

    x = 16'sh7FFF; baseline = 16'sh8000;
    tick(DELAY + 1);
    check("sat_pos", int'(y), 32767);
    x = 16'sh8000; baseline = 16'sh7FFF;
    tick(DELAY + 1);
    check("sat_neg", int'(y), -32768);
    $display("[TB] saturation checked");

    x = 16'sd100; baseline = 16'sd100;
    tick(8);
    baseline_valid = 1'b0;
    tick(1);
    check("bv_drop_state", int'(state_o), 1);
    check("bv_drop_y_valid", int'(y_valid), 0);
    check("bv_drop_y", int'(y), 0);
    baseline_valid = 1'b1;
    tick(15);
    check("rewait_15", int'(state_o), 1);
    tick(1);
    check("rerun_16", int'(state_o), 2);
    en = 1'b0;
    tick(1);
    check("en_off_state", int'(state_o), 0);
    check("en_off_y", int'(y), 0);
    check("delay_cleared", int'(dut.xd), 0);
    en = 1'b1; x = 16'sd500;
    tick(1);
    check("delay_zero_on_reenable", int'(dut.xd), 0);
    check("reenable_wait", int'(state_o), 1);
    tick(16);
    check("reenable_run", int'(state_o), 2);
    check("reenable_y", int'(y), 400);
    $display("[TB] baseline drop and re-enable checked");

    tick(2);
    check("pre_reset_y", int'(y), 400);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_y", int'(y), 0);
    check("async_rst_y_valid", int'(y_valid), 0);
    check("async_rst_trig", int'(trig), 0);
    check("async_rst_state", int'(state_o), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("recover_wait", int'(state_o), 1);
    tick(16);
    check("recover_run", int'(state_o), 2);
    $display("[TB] async reset mid-RUN checked");

    tick(3);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
